// File: rtl/arb_pkg.sv
// Shared types and the round-robin pick used by the memory port arbiter.
// Latency: n/a (types and a combinational helper only).
// Backpressure: n/a.
package arb_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    // Widest requester set the pick function is written for.
    localparam int MAX_REQ = 4;

    // Winner is the first set req bit searching from ptr+1 upward, wrapping at nreq.
    // Falls back to index 0 when nothing is requested; callers gate on |req.
    function automatic logic [1:0] rr_pick(input logic [3:0] req,
                                           input logic [1:0] ptr,
                                           input int         nreq);
        logic [1:0] win;
        logic       found;
        int         idx;
        win   = '0;
        found = 1'b0;
        for (int i = 1; i <= MAX_REQ; i++) begin
            idx = (int'(ptr) + i) % nreq;
            if ((i <= nreq) && !found && req[idx[1:0]]) begin
                win   = idx[1:0];
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/arb_mem.sv
// Single-port DW x 2**AW memory with a registered read port.
// Latency: write commits at the closing edge; read data appears 1 cycle after rd.
// Backpressure: none; one access per cycle, rdata holds when rd is low.
module arb_mem #(
    parameter int AW = 3,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          rd,
    input  logic          wr,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    // Storage array: written on a granted write, contents survive reset.
    always_ff @(posedge clk) begin
        if (wr) begin
            mem[addr] <= wdata;
        end
    end

    // Read register: captures the addressed word on rd, otherwise holds.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            rdata <= '0;
        end else if (rd) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter with per-requester lock sharing one memory port among NREQ masters.
// Latency: grant is combinational; writes commit at the grant edge; rvalid/rdata 1 cycle after a read grant.
// Backpressure: losers (and non-owners while locked) simply see no gnt and must hold req/addr/wdata.
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int AW   = 3,
    parameter int DW   = 8
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          lock,
    input  logic [NREQ-1:0]          we,
    input  logic [NREQ*AW-1:0]       addr,
    input  logic [NREQ*DW-1:0]       wdata,
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          rvalid,
    output logic [DW-1:0]            rdata,
    output logic [$clog2(NREQ)-1:0]  owner,
    output logic                     locked
);

    localparam int IW = $clog2(NREQ);

    arb_state_t      state;
    arb_state_t      state_nxt;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   win;
    logic [IW-1:0]   sel;
    logic            sel_vld;
    logic [NREQ-1:0] rv_q;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic            mem_rd;
    logic            mem_wr;

    assign win = IW'(rr_pick(4'(req), 2'(ptr), NREQ));

    // Next state and the selected requester for this cycle's single access.
    always_comb begin
        state_nxt = state;
        sel       = win;
        sel_vld   = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (|req) begin
                    sel     = win;
                    sel_vld = 1'b1;
                    if (lock[win]) begin
                        state_nxt = ARB_LOCKED;
                    end
                end
            end
            ARB_LOCKED: begin
                // Only the owner may access; dropping lock still allows this final access.
                sel     = owner;
                sel_vld = req[owner];
                if (!lock[owner]) begin
                    state_nxt = ARB_IDLE;
                end
            end
            default: begin
                state_nxt = ARB_IDLE;
            end
        endcase
        // No access may happen during a reset cycle, so a write there never commits.
        if (!nrst) begin
            sel_vld = 1'b0;
        end
    end

    // One-hot grant and the request mux feeding the memory.
    always_comb begin
        gnt = '0;
        for (int k = 0; k < NREQ; k++) begin
            gnt[k] = sel_vld && (int'(sel) == k);
        end
        mem_addr  = addr[sel*AW +: AW];
        mem_wdata = wdata[sel*DW +: DW];
        mem_rd    = sel_vld && !we[sel];
        mem_wr    = sel_vld && we[sel];
    end

    // FSM state, round-robin pointer, owner and the read-return tag.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state <= ARB_IDLE;
            ptr   <= IW'(NREQ - 1);
            owner <= '0;
            rv_q  <= '0;
        end else begin
            state <= state_nxt;
            // While locked ptr already equals owner, so only IDLE grants move them.
            if (sel_vld && (state == ARB_IDLE)) begin
                ptr   <= sel;
                owner <= sel;
            end
            rv_q <= mem_rd ? gnt : '0;
        end
    end

    // Reset kills an in-flight read return and a held lock in the same cycle it is asserted.
    assign rvalid = nrst ? rv_q : '0;
    assign locked = nrst && (state == ARB_LOCKED);

    arb_mem #(
        .AW (AW),
        .DW (DW)
    ) u_mem (
        .clk   (clk),
        .nrst  (nrst),
        .rd    (mem_rd),
        .wr    (mem_wr),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a read-return scoreboard.
// Latency: read expectations are queued at grant time and popped when rvalid shows.
// Backpressure: n/a (bench drives one vector per cycle).
module tb_mem_port_arbiter;

    logic        clk;
    logic        nrst;
    logic [1:0]  req;
    logic [1:0]  lock;
    logic [1:0]  we;
    logic [5:0]  addr;
    logic [15:0] wdata;
    logic [1:0]  gnt;
    logic [1:0]  rvalid;
    logic [7:0]  rdata;
    logic        owner;
    logic        locked;

    int n_pass  = 0;
    int n_total = 0;

    // Expected read returns: {rvalid one-hot, rdata}.
    logic [9:0] exp_q[$];

    mem_port_arbiter #(.NREQ(2), .AW(3), .DW(8)) dut (
        .clk    (clk),
        .nrst   (nrst),
        .req    (req),
        .lock   (lock),
        .we     (we),
        .addr   (addr),
        .wdata  (wdata),
        .gnt    (gnt),
        .rvalid (rvalid),
        .rdata  (rdata),
        .owner  (owner),
        .locked (locked)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive one cycle's vector just after the edge, then check gnt and the registered state.
    task automatic step(input logic n, input logic [1:0] r, input logic [1:0] l,
                        input logic [1:0] w, input logic [2:0] a0, input logic [2:0] a1,
                        input logic [7:0] d0, input logic [7:0] d1,
                        input logic [1:0] eg, input logic eo, input logic el,
                        input string nm);
        @(posedge clk);
        #1;
        nrst  = n;
        req   = r;
        lock  = l;
        we    = w;
        addr  = {a1, a0};
        wdata = {d1, d0};
        #3;
        chk({nm, " gnt"}, 32'(gnt), 32'(eg));
        chk({nm, " owner"}, 32'(owner), 32'(eo));
        chk({nm, " locked"}, 32'(locked), 32'(el));
    endtask

    task automatic push(input logic [1:0] v, input logic [7:0] d);
        exp_q.push_back({v, d});
    endtask

    // Monitor: every read return must match the oldest queued expectation.
    always @(negedge clk) begin
        logic [9:0] e;
        if (rvalid != 2'b00) begin
            if (exp_q.size() == 0) begin
                chk("spurious rvalid", 32'(rvalid), 32'h0);
            end else begin
                e = exp_q.pop_front();
                chk("rvalid", 32'(rvalid), 32'(e[9:8]));
                chk("rdata", 32'(rdata), 32'(e[7:0]));
            end
        end
    end

    initial begin
        nrst  = 1'b0;
        req   = '0;
        lock  = '0;
        we    = '0;
        addr  = '0;
        wdata = '0;
        repeat (2) @(posedge clk);

        // Reset: grant suppressed, outputs at reset values.
        step(0, 2'b01, 2'b01, 2'b00, 3'd3, 3'd0, 8'h00, 8'h00, 2'b00, 0, 0, "rst");
        chk("rst rvalid", 32'(rvalid), 32'h0);
        chk("rst rdata", 32'(rdata), 32'h0);

        // Write then read addr 3 from requester 0.
        step(1, 2'b01, 2'b00, 2'b01, 3'd3, 3'd0, 8'hA5, 8'h00, 2'b01, 0, 0, "wr3");
        step(1, 2'b01, 2'b00, 2'b00, 3'd3, 3'd0, 8'h00, 8'h00, 2'b01, 0, 0, "rd3");
        push(2'b01, 8'hA5);

        // Fill addr 1 and 2; the second write leaves the pointer at requester 1.
        step(1, 2'b01, 2'b00, 2'b01, 3'd1, 3'd0, 8'h21, 8'h00, 2'b01, 0, 0, "wr1");
        step(1, 2'b10, 2'b00, 2'b10, 3'd0, 3'd2, 8'h00, 8'h32, 2'b10, 0, 0, "wr2");

        // Both requesting reads: strict alternation starting at requester 0.
        for (int i = 0; i < 4; i++) begin
            step(1, 2'b11, 2'b00, 2'b00, 3'd1, 3'd2, 8'h00, 8'h00,
                 (i % 2 == 0) ? 2'b01 : 2'b10, (i % 2 == 0), 0, "rr");
            push((i % 2 == 0) ? 2'b01 : 2'b10, (i % 2 == 0) ? 8'h21 : 8'h32);
        end

        // Requester 1 locks for five accesses while requester 0 waits.
        step(1, 2'b01, 2'b00, 2'b01, 3'd4, 3'd0, 8'h44, 8'h00, 2'b01, 1, 0, "wr4");
        step(1, 2'b11, 2'b10, 2'b10, 3'd1, 3'd5, 8'h00, 8'h55, 2'b10, 0, 0, "lk1 wr5");
        step(1, 2'b11, 2'b10, 2'b00, 3'd1, 3'd5, 8'h00, 8'h00, 2'b10, 1, 1, "lk1 rd5");
        push(2'b10, 8'h55);
        step(1, 2'b11, 2'b10, 2'b00, 3'd1, 3'd2, 8'h00, 8'h00, 2'b10, 1, 1, "lk1 rd2");
        push(2'b10, 8'h32);
        step(1, 2'b11, 2'b10, 2'b00, 3'd1, 3'd4, 8'h00, 8'h00, 2'b10, 1, 1, "lk1 rd4");
        push(2'b10, 8'h44);
        step(1, 2'b11, 2'b00, 2'b00, 3'd1, 3'd3, 8'h00, 8'h00, 2'b10, 1, 1, "lk1 final");
        push(2'b10, 8'hA5);
        step(1, 2'b11, 2'b00, 2'b00, 3'd1, 3'd0, 8'h00, 8'h00, 2'b01, 1, 0, "after unlock");
        push(2'b01, 8'h21);

        // Owner 0 locks, idles two cycles holding lock while requester 1 waits.
        step(1, 2'b01, 2'b01, 2'b00, 3'd3, 3'd0, 8'h00, 8'h00, 2'b01, 0, 0, "lk0 rd3");
        push(2'b01, 8'hA5);
        step(1, 2'b10, 2'b01, 2'b00, 3'd3, 3'd2, 8'h00, 8'h00, 2'b00, 0, 1, "lk0 stall a");
        step(1, 2'b10, 2'b01, 2'b00, 3'd3, 3'd2, 8'h00, 8'h00, 2'b00, 0, 1, "lk0 stall b");
        step(1, 2'b11, 2'b00, 2'b00, 3'd4, 3'd2, 8'h00, 8'h00, 2'b01, 0, 1, "lk0 final");
        push(2'b01, 8'h44);
        step(1, 2'b10, 2'b00, 2'b00, 3'd0, 3'd2, 8'h00, 8'h00, 2'b10, 0, 0, "req1 served");
        push(2'b10, 8'h32);

        // Write from requester 0 seen by requester 1 on the very next grant.
        step(1, 2'b01, 2'b00, 2'b01, 3'd0, 3'd0, 8'h11, 8'h00, 2'b01, 1, 0, "wr0");
        step(1, 2'b10, 2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 2'b10, 0, 0, "rd0 by 1");
        push(2'b10, 8'h11);

        // Locked read of addr 7, then reset: no return, lock gone, reset-cycle write lost.
        step(1, 2'b01, 2'b01, 2'b00, 3'd7, 3'd0, 8'h00, 8'h00, 2'b01, 1, 0, "lk0 rd7");
        step(0, 2'b01, 2'b00, 2'b01, 3'd0, 3'd0, 8'hEE, 8'h00, 2'b00, 0, 0, "mid rst");
        chk("mid rst rvalid", 32'(rvalid), 32'h0);
        step(1, 2'b11, 2'b00, 2'b00, 3'd0, 3'd3, 8'h00, 8'h00, 2'b01, 0, 0, "post rst");
        push(2'b01, 8'h11);
        step(1, 2'b00, 2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 2'b00, 0, 0, "drain a");
        step(1, 2'b00, 2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 2'b00, 0, 0, "drain b");

        chk("pending returns", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one 8-entry x 8-bit synchronous-read memory between NREQ requesters, for example a host load/unload port and the sort engine.
- Uses round-robin arbitration with a per-requester lock, so one master can own the port for a multi-cycle burst such as a full sort pass.
- Sits between the requesters and the memory instance, replacing the ad-hoc address/enable muxing around the memory.

Parameters:
- NREQ, 2, number of requesters (2..4)
- AW, 3, address width (memory depth 2**AW)
- DW, 8, data width

Ports:
- clk  in  1  clock, all state changes on posedge
- nrst  in  1  reset, synchronous, active-low
- req  in  NREQ  per-requester access request, held until granted
- lock  in  NREQ  per-requester lock; meaningful only together with its req
- we  in  NREQ  per-requester access type: 1 = write, 0 = read
- addr  in  NREQ*AW  packed addresses; requester k uses slice [k*AW +: AW]
- wdata  in  NREQ*DW  packed write data; requester k uses slice [k*DW +: DW]
- gnt  out  NREQ  one-hot grant; the access happens in this cycle
- rvalid  out  NREQ  one-hot; pulses 1 cycle after a granted read, for that requester
- rdata  out  DW  read data, shared; valid when any rvalid bit is set
- owner  out  $clog2(NREQ)  index of the last or current grantee
- locked  out  1  1 while the arbiter is in state LOCKED

Behaviour:
- Reset (nrst=0 at posedge):
  - state = IDLE, rr pointer = NREQ-1 (so requester 0 wins first), owner = 0, locked = 0.
  - rvalid = 0, rdata = 0.
  - gnt is forced to 0 during any cycle where nrst=0.
  - Memory contents are not reset.
- gnt is combinational from req, state and the pointer. At most one bit is ever set. A cycle with gnt[k]=1 is exactly one memory access for requester k.
- IDLE:
  - Winner is the first requester with req=1, searching (ptr+1) mod NREQ upward with wrap-around.
  - On a grant, ptr and owner are set to the winner.
  - If lock[winner]=1 in the grant cycle, next state = LOCKED. Otherwise stay IDLE.
  - No req bit set: no grant, ptr unchanged.
- LOCKED:
  - Only owner can be granted: gnt[owner] = req[owner]. All other requests stall, with no grant and their req held.
  - Owner may drop req while keeping lock: the port idles and stays LOCKED. Stalling is legal.
  - Owner drops lock: this cycle is still granted if req[owner]=1 (the final access), and next state = IDLE.
  - ptr stays equal to owner, so after release the next IDLE arbitration starts at owner+1.
- Access timing:
  - Write: mem[addr_k] <= wdata_k at the posedge closing the grant cycle.
  - Read: the memory captures mem[addr_k] at that posedge. rdata is valid and rvalid[k]=1 for exactly the following cycle. rvalid is 0 otherwise.
  - rdata holds its last value when rvalid=0.
  - Back-to-back grants give back-to-back rvalid pulses. Throughput is 1 access per cycle.
- Ordering:
  - A read granted the cycle after a write to the same address returns the new data.
  - Only one access per cycle exists, so there is no same-cycle collision.
- Reset mid-operation:
  - A read granted in the cycle before reset produces no rvalid.
  - A lock is dropped immediately.
  - A write granted in the same cycle as nrst=0 does not commit, because gnt=0.
- Requesters must hold req, we, addr and wdata stable until gnt. The arbiter does not register requests.

Decomposition:
- Package arb_pkg holds:
  - typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t
  - function rr_pick(req, ptr) returning the round-robin winner index
- One sub-module, arb_mem: DW x 2**AW array, with a registered read enabled by rd and a write enabled by wr. It matches the existing memory's 1-cycle read.
- The arbiter holds the FSM, the pointer, the request mux and the rvalid tag register.

Test Plan:
- Reset, then req=01, we0=1, addr0=3, wdata0=8'hA5; next cycle req=01, we0=0, addr0=3 -> gnt=01 on both cycles; rvalid=01 and rdata=8'hA5 on the third cycle.
- req=11 held, all reads, for 4 cycles -> gnt sequence 01, 10, 01, 10; rvalid follows one cycle later; owner toggles 0, 1, 0, 1.
- req1=1 with lock1=1 for 5 accesses while req0=1 is held -> gnt=10 on all 5 cycles and gnt[0]=0; locked=1 from cycle 2. On the cycle lock1 drops, gnt=10 is the final access; the next cycle gives gnt=01.
- LOCKED owner 0 drops req0 for 2 cycles with lock0=1, while req1=1 -> gnt=00 on those cycles, locked stays 1, no rvalid.
- Granted read to addr 7, with nrst=0 asserted in the next cycle -> rvalid stays 0, locked=0, and after release requester 0 wins first.
- Write addr 0 = 8'h11 from requester 0, then a read of addr 0 from requester 1 on the immediately following grant -> rvalid=10, rdata=8'h11.
